uart_byte_arbiter: RTL and testbench
====================================

// Module: uart_byte_arbiter
// PURPOSE
//  Shares the single uart_tx byte transmitter between two requesters:
//  - the pixel byte stream (frame_end_stuffer output), buffered in an internal FIFO;
//  - a multi-byte status message source (e.g. the per-frame pixel-count string).
//  Sits between the camera datapath and uart_tx. Sequences strobe/busy handshakes,
//  keeps each status message atomic, and reports pixel-FIFO overflow.
// PARAMETERS
//  FIFO_DEPTH  16  pixel FIFO entries; power of two, >= 2
//  MSG_MAX     8   max status message length in bytes; msg_len saturates here
// PORTS
//  clock           in   1   system clock (osc_12m domain)
//  reset           in   1   synchronous, active-low
//  pix_valid       in   1   push pix_data into FIFO this cycle; no backpressure
//  pix_data        in   8   pixel/delimiter byte
//  frame_active    in   1   high while a frame is streaming (synchronised vsync)
//  msg_req         in   1   level; message source has a message pending
//  msg_len         in   4   bytes in message, sampled at message start
//  msg_idx         out  4   index of byte requested from message source
//  msg_data        in   8   byte at msg_idx, combinational from source
//  msg_ack         out  1   1-cycle pulse: message fully handed to uart_tx
//  uart_strobe     out  1   1-cycle strobe to uart_tx data_valid
//  uart_data       out  8   byte to uart_tx, valid while uart_strobe = 1
//  uart_busy       in   1   uart_tx busy; rises cycle after strobe at latest
//  ovf_clear       in   1   clears overflow
//  overflow        out  1   sticky: a pixel byte was dropped
//  fifo_level      out  clog2(FIFO_DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset (reset = 0 at posedge): FIFO emptied, state IDLE, all outputs 0
//  (uart_strobe, uart_data, msg_idx, msg_ack, overflow, fifo_level).
//  Reset mid-byte or mid-message abandons it; no msg_ack is issued.
//  FIFO:
//  - push on pix_valid; pop when a pixel strobe is issued.
//  - push + pop same cycle when full: both happen, level unchanged.
//  - push when full without pop: byte dropped, overflow <= 1.
//  - ovf_clear and a simultaneous drop: overflow stays 1 (set wins).
//  - fifo_level is registered: reflects the state after the previous edge.
//  FSM states: IDLE, STROBE, GUARD, BUSY. A src register holds PIX or MSG.
//  - IDLE, chosen in priority order:
//    (1) a message is in progress -> MSG;
//    (2) fifo_level != 0 -> PIX;
//    (3) msg_req && !frame_active -> start message: latch min(msg_len, MSG_MAX), msg_idx <= 0;
//        latched length 0 -> msg_ack pulses next cycle, no bytes sent;
//    (4) otherwise stay in IDLE.
//    Once started, a message is never interrupted; pixel bytes queue in the FIFO.
//  - STROBE: uart_strobe = 1 for exactly one cycle. uart_data is registered:
//    FIFO head (PIX, popped this cycle) or msg_data (MSG) -> GUARD.
//  - GUARD: one cycle, ignores uart_busy -> BUSY.
//  - BUSY: stay while uart_busy. On !uart_busy:
//    - MSG: msg_idx++. After the last byte, msg_idx <= 0, msg_ack pulses, -> IDLE;
//    - otherwise -> IDLE.
//  Latency: pix_valid at cycle N into an empty FIFO with FSM in IDLE -> strobe at N+2.
//  Minimum spacing between strobes: 4 cycles.
//  msg_req falling mid-message is ignored; a message is only started when msg_req is
//  high, the FSM is in IDLE, and the FIFO is empty.
// TESTING
//  T1: reset low 3 cycles with pix_valid=1 -> fifo_level=0, uart_strobe=0, overflow=0.
//  T2: push 0xA5 into empty FIFO, busy model 10 cycles -> strobe 2 cycles later with
//      uart_data=0xA5; next strobe no earlier than busy fall + 1.
//  T3: frame_active=0, msg_req=1, msg_len=8, source bytes "000F00\r\n" -> 8 strobes in
//      order, msg_idx 0..7; single msg_ack after the 8th busy fall.
//  T4: push 3 pixels during message byte 2 -> remaining 6 message bytes first, then
//      3 pixels; no interleave.
//  T5: FIFO_DEPTH=16, hold busy high, push 17 bytes -> level 16, overflow=1, 17th dropped;
//      ovf_clear -> overflow 0.
//  T6: msg_req=1 with frame_active=1 -> no message byte sent; on frame_active fall with
//      FIFO drained, message starts. msg_len=0 -> msg_ack, zero strobes.

Source files
------------

// File: rtl/uart_byte_arbiter.sv
// Shares one uart_tx between a FIFO-buffered pixel byte stream and atomic multi-byte
// status messages, sequencing the strobe/busy handshake and flagging pixel overflow.
module uart_byte_arbiter #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MSG_MAX    = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pix_valid,
  input  logic [7:0]                  pix_data,
  input  logic                        frame_active,
  input  logic                        msg_req,
  input  logic [3:0]                  msg_len,
  output logic [3:0]                  msg_idx,
  input  logic [7:0]                  msg_data,
  output logic                        msg_ack,
  output logic                        uart_strobe,
  output logic [7:0]                  uart_data,
  input  logic                        uart_busy,
  input  logic                        ovf_clear,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStrobe, StGuard, StBusy} state_e;
  typedef enum logic {SrcPix, SrcMsg} src_e;

  state_e state_q, state_d;
  src_e   src_q, src_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;

  logic       msg_active_q;
  logic [3:0] msg_len_q;
  logic [3:0] msg_idx_q;
  logic       msg_ack_q;
  logic [7:0] uart_data_q;

  logic       full, push, pop, drop;
  logic       load_byte, msg_start, msg_step;
  logic [3:0] len_sat;
  logic [7:0] byte_d;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop     = (state_q == StStrobe) && (src_q == SrcPix);
  // A full FIFO still accepts a byte in the cycle its head is popped.
  assign push    = pix_valid && (!full || pop);
  assign drop    = pix_valid && full && !pop;
  assign len_sat = (msg_len > 4'(MSG_MAX)) ? 4'(MSG_MAX) : msg_len;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= pix_data;
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    load_byte = 1'b0;
    msg_start = 1'b0;
    msg_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (msg_active_q) begin
          state_d   = StStrobe;
          src_d     = SrcMsg;
          load_byte = 1'b1;
        end else if (level_q != '0) begin
          state_d   = StStrobe;
          src_d     = SrcPix;
          load_byte = 1'b1;
        end else if (msg_req && !frame_active) begin
          msg_start = 1'b1;
        end
      end
      StStrobe: state_d = StGuard;
      StGuard:  state_d = StBusy;
      StBusy: begin
        if (!uart_busy) begin
          state_d  = StIdle;
          msg_step = (src_q == SrcMsg);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign byte_d = (src_d == SrcMsg) ? msg_data : mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      src_q        <= SrcPix;
      msg_active_q <= 1'b0;
      msg_len_q    <= '0;
      msg_idx_q    <= '0;
      msg_ack_q    <= 1'b0;
      uart_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      msg_ack_q <= 1'b0;
      if (load_byte) uart_data_q <= byte_d;
      if (msg_start) begin
        msg_len_q <= len_sat;
        msg_idx_q <= '0;
        // An empty message completes immediately without touching the UART.
        if (len_sat == '0) begin
          msg_ack_q <= 1'b1;
        end else begin
          msg_active_q <= 1'b1;
        end
      end
      if (msg_step) begin
        if (msg_idx_q == msg_len_q - 4'd1) begin
          msg_idx_q    <= '0;
          msg_active_q <= 1'b0;
          msg_ack_q    <= 1'b1;
        end else begin
          msg_idx_q <= msg_idx_q + 4'd1;
        end
      end
    end
  end

  assign uart_strobe = (state_q == StStrobe);
  assign uart_data   = uart_data_q;
  assign msg_idx     = msg_idx_q;
  assign msg_ack     = msg_ack_q;
  assign overflow    = overflow_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_uart_byte_arbiter.sv
// Randomised bench for uart_byte_arbiter: a queue-based model of the expected byte
// stream, FIFO occupancy and overflow, plus a uart_tx busy responder.
module tb_uart_byte_arbiter;

  localparam int unsigned Depth = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       frame_active = 1'b0;
  logic       msg_pend = 1'b0;
  logic       msg_req;
  logic [3:0] msg_len = '0;
  logic [3:0] msg_idx;
  logic [7:0] msg_data;
  logic       msg_ack;
  logic       uart_strobe;
  logic [7:0] uart_data;
  logic       uart_busy = 1'b0;
  logic       ovf_clear = 1'b0;
  logic       overflow;
  logic [4:0] fifo_level;

  logic [7:0] msg_buf [16];

  typedef struct {
    logic [7:0] data;
    bit         is_msg;
    int         idx;
    bit         is_last;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_vec = 0, n_err = 0;
  int cyc = 0;
  int n_strobe = 0, ack_cnt = 0;
  int last_strobe = -1000, fall_cyc = -1000, ack_due = -1;
  int busy_left = 0, busy_force = 0;
  bit hold_busy = 1'b0, pend_last = 1'b0;
  int mlev = 0;
  bit movf = 1'b0;

  uart_byte_arbiter #(.FIFO_DEPTH(Depth), .MSG_MAX(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .frame_active (frame_active),
    .msg_req      (msg_req),
    .msg_len      (msg_len),
    .msg_idx      (msg_idx),
    .msg_data     (msg_data),
    .msg_ack      (msg_ack),
    .uart_strobe  (uart_strobe),
    .uart_data    (uart_data),
    .uart_busy    (uart_busy),
    .ovf_clear    (ovf_clear),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  // The message source drops its request as soon as the arbiter acknowledges.
  assign msg_req  = msg_pend && !msg_ack;
  assign msg_data = msg_buf[msg_idx];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Model: busy responder, expected strobe stream, FIFO occupancy and overflow.
  initial begin : monitor
    exp_t e;
    exp_t p;
    bit   pop_pix;
    bit   drop;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mlev = 0;
        movf = 1'b0;
        exp_q.delete();
        uart_busy = 1'b0;
        busy_left = 0;
        pend_last = 1'b0;
        ack_due   = -1;
        continue;
      end
      check("fifo_level", 32'(fifo_level), 32'(mlev));
      check("overflow", 32'(overflow), 32'(movf));
      pop_pix = 1'b0;
      if (msg_ack) begin
        ack_cnt++;
        if (ack_due >= 0) begin
          check("ack_time", cyc, ack_due);
          ack_due = -1;
        end
      end
      if (uart_strobe) begin
        check("strobe_expected", 32'(exp_q.size() != 0), 1);
        check("strobe_spacing", 32'(cyc - last_strobe >= 4), 1);
        check("strobe_after_fall", 32'(cyc >= fall_cyc + 2), 1);
        last_strobe = cyc;
        n_strobe++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("uart_data", 32'(uart_data), 32'(e.data));
          if (e.is_msg) check("msg_idx", 32'(msg_idx), e.idx);
          pop_pix   = !e.is_msg;
          pend_last = e.is_last;
        end
        busy_left = (busy_force != 0) ? busy_force : int'($urandom_range(2, 6));
        uart_busy = 1'b1;
      end else if (uart_busy && !hold_busy) begin
        if (busy_left > 1) begin
          busy_left--;
        end else begin
          uart_busy = 1'b0;
          fall_cyc  = cyc;
          if (pend_last) begin
            ack_due   = cyc + 1;
            pend_last = 1'b0;
          end
        end
      end
      drop = 1'b0;
      if (pix_valid) begin
        if (mlev < Depth || pop_pix) begin
          p.data = pix_data; p.is_msg = 1'b0; p.idx = 0; p.is_last = 1'b0;
          exp_q.push_back(p);
          mlev++;
        end else begin
          drop = 1'b1;
        end
      end
      if (pop_pix) mlev--;
      if (drop) movf = 1'b1;
      else if (ovf_clear) movf = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_pix(input logic [7:0] b);
    pix_valid = 1'b1;
    pix_data  = b;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic rand_buf();
    for (int i = 0; i < 16; i++) msg_buf[i] = 8'($urandom);
  endtask

  task automatic queue_msg(input int len);
    exp_t m;
    int n;
    n = (len > 8) ? 8 : len;
    for (int i = 0; i < n; i++) begin
      m.data = msg_buf[i]; m.is_msg = 1'b1; m.idx = i; m.is_last = (i == n - 1);
      exp_q.push_back(m);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || uart_busy) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("drained", exp_q.size(), 0);
  endtask

  task automatic wait_ack(input int a0, input int budget, input bit rnd_pix);
    int n;
    n = 0;
    while (ack_cnt == a0 && n < budget) begin
      pix_valid = rnd_pix && ($urandom_range(0, 3) == 0);
      pix_data  = 8'($urandom);
      tick();
      n++;
    end
    pix_valid = 1'b0;
    msg_pend  = 1'b0;
  endtask

  initial begin : driver
    int a0, s0, push_cyc, n, len;
    logic [7:0] t3_bytes [8];
    t3_bytes = '{8'h30, 8'h30, 8'h30, 8'h46, 8'h30, 8'h30, 8'h0d, 8'h0a};
    rand_buf();

    // T1: reset held with pix_valid asserted
    pix_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    pix_valid = 1'b0;
    check("t1_level", 32'(fifo_level), 0);
    check("t1_strobe", 32'(uart_strobe), 0);
    check("t1_ovf", 32'(overflow), 0);
    check("t1_idx", 32'(msg_idx), 0);
    check("t1_ack", 32'(msg_ack), 0);
    check("t1_data", 32'(uart_data), 0);

    // T2: single pixel latency, then a second byte queued behind a long busy
    busy_force = 10;
    s0 = n_strobe;
    push_cyc = cyc;
    push_pix(8'hA5);
    n = 0;
    while (n_strobe == s0 && n < 10) begin tick(); n++; end
    check("t2_latency", last_strobe - push_cyc, 2);
    push_pix(8'h5A);
    wait_drain(100);
    busy_force = 0;

    // T3: fixed 8-byte status string
    for (int i = 0; i < 8; i++) msg_buf[i] = t3_bytes[i];
    msg_len = 4'd8;
    queue_msg(8);
    a0 = ack_cnt;
    msg_pend = 1'b1;
    wait_ack(a0, 200, 1'b0);
    wait_drain(100);
    check("t3_ack_count", ack_cnt - a0, 1);
    check("t3_idx_rest", 32'(msg_idx), 0);

    // T4: pixels arriving mid-message wait until the message completes
    rand_buf();
    queue_msg(8);
    a0 = ack_cnt;
    s0 = n_strobe;
    msg_pend = 1'b1;
    n = 0;
    while (n_strobe < s0 + 2 && n < 60) begin tick(); n++; end
    for (int i = 0; i < 3; i++) push_pix(8'($urandom));
    wait_ack(a0, 200, 1'b0);
    wait_drain(200);
    check("t4_ack_count", ack_cnt - a0, 1);

    // T5: overflow with the UART stalled
    hold_busy = 1'b1;
    push_pix(8'h11);
    repeat (4) tick();
    for (int i = 0; i < 17; i++) push_pix(8'($urandom));
    check("t5_level", 32'(fifo_level), 16);
    check("t5_ovf", 32'(overflow), 1);
    ovf_clear = 1'b1;
    push_pix(8'hEE);
    ovf_clear = 1'b0;
    check("t5_ovf_set_wins", 32'(overflow), 1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("t5_ovf_cleared", 32'(overflow), 0);
    hold_busy = 1'b0;
    wait_drain(400);

    // T6: message held off by frame_active, then an empty message
    frame_active = 1'b1;
    rand_buf();
    msg_len = 4'd5;
    msg_pend = 1'b1;
    s0 = n_strobe;
    for (int i = 0; i < 4; i++) begin push_pix(8'($urandom)); tick(); end
    wait_drain(200);
    repeat (8) tick();
    check("t6_pixels_only", n_strobe - s0, 4);
    queue_msg(5);
    a0 = ack_cnt;
    frame_active = 1'b0;
    wait_ack(a0, 200, 1'b0);
    wait_drain(100);
    check("t6_ack_count", ack_cnt - a0, 1);
    msg_len = 4'd0;
    a0 = ack_cnt;
    s0 = n_strobe;
    msg_pend = 1'b1;
    wait_ack(a0, 20, 1'b0);
    repeat (8) tick();
    check("t6_zero_strobes", n_strobe - s0, 0);
    check("t6_zero_ack", ack_cnt - a0, 1);

    // Reset mid-message abandons it without an ack
    rand_buf();
    msg_len = 4'd8;
    queue_msg(8);
    a0 = ack_cnt;
    s0 = n_strobe;
    msg_pend = 1'b1;
    n = 0;
    while (n_strobe < s0 + 3 && n < 80) begin tick(); n++; end
    reset = 1'b0;
    msg_pend = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (20) tick();
    check("rst_no_ack", ack_cnt - a0, 0);
    check("rst_idx", 32'(msg_idx), 0);

    // Random pixel traffic with overflow and clears
    for (int i = 0; i < 300; i++) begin
      pix_valid    = ($urandom_range(0, 3) != 0);
      pix_data     = 8'($urandom);
      frame_active = 1'($urandom);
      ovf_clear    = ($urandom_range(0, 15) == 0);
      tick();
    end
    pix_valid = 1'b0;
    ovf_clear = 1'b0;
    frame_active = 1'b0;
    wait_drain(400);

    // Random messages (including saturating lengths) with pixels arriving meanwhile
    for (int k = 0; k < 6; k++) begin
      rand_buf();
      len = int'($urandom_range(0, 15));
      msg_len = 4'(len);
      queue_msg(len);
      a0 = ack_cnt;
      msg_pend = 1'b1;
      wait_ack(a0, 200, 1'b1);
      wait_drain(400);
      check("rnd_ack_count", ack_cnt - a0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
